dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 193 +++++++++++++++++++
 tb/tb_dmem_resp.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory response block: accepts one load/store request at a time,
// holds it for a fixed latency, performs the access against byte-lane
// storage, then presents a one-cycle response with extended load data.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  // Captured copy of the accepted request; the live inputs are ignored
  // until the block returns to IDLE.
  logic        rd_reg, wr_reg, sign_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [1:0]  size_reg;

  logic        accept;
  logic        access;
  logic        err_c;
  logic        out_of_range;
  logic        do_write, do_read;
  logic [3:0]  be;
  logic [31:0] wdata_lane;
  logic [31:0] rd_word;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;
  logic [31:0] word_idx;
  logic [AW-1:0] mem_idx;

  assign accept = (state_reg == IDLE) && req_valid_i;

  // State and latency counter; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: count down in BUSY, access on the zero-count edge.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    req_ready_o = 1'b0;
    access      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_next = BUSY;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture at the accept edge.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      sign_reg  <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      size_reg  <= 2'd0;
    end else if (accept) begin
      rd_reg    <= rd_en_i;
      wr_reg    <= wr_en_i;
      sign_reg  <= sign_i;
      addr_reg  <= addr_i;
      wdata_reg <= wdata_i;
      size_reg  <= size_i;
    end
  end

  // Fault decode on the captured request: bad size, misalignment,
  // out-of-range word, or not exactly one of load/store.
  always_comb begin
    word_idx     = {2'b00, addr_reg[31:2]};
    out_of_range = (word_idx >= 32'(DEPTH_WORDS));
    err_c = (size_reg == 2'd3)
          || ((size_reg == 2'd1) && addr_reg[0])
          || ((size_reg == 2'd2) && (addr_reg[1:0] != 2'b00))
          || out_of_range
          || (rd_reg == wr_reg);
  end

  assign mem_idx  = addr_reg[AW+1:2];
  // Reset is also checked here so a reset landing on the access edge
  // can never let the store slip through.
  assign do_write = access && wr_reg && !err_c && !rst_i;
  assign do_read  = access && rd_reg && !err_c;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata_reg;
    case (size_reg)
      2'd0: begin
        be         = 4'b0001 << addr_reg[1:0];
        wdata_lane = {4{wdata_reg[7:0]}};
      end
      2'd1: begin
        be         = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_reg[15:0]}};
      end
      2'd2: begin
        be         = 4'b1111;
        wdata_lane = wdata_reg;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = wdata_reg;
      end
    endcase
  end

  // One RAM per byte lane so partial stores map onto lane write enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_byte_reg;

    // Lane write and registered read, both on the access edge.
    always_ff @(posedge clk) begin
      if (do_write && be[gi]) begin
        mem[mem_idx] <= wdata_lane[8*gi +: 8];
      end
      if (do_read) begin
        rd_byte_reg <= mem[mem_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_reg;
  end

  // Load alignment and extension; sign_i=1 selects zero-extension.
  always_comb begin
    rd_shifted = rd_word >> {addr_reg[1:0], 3'b000};
    case (size_reg)
      2'd0:    load_data = {{24{!sign_reg && rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_data = {{16{!sign_reg && rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Response outputs are forced to zero outside the RESP cycle.
  always_comb begin
    rsp_valid_o = (state_reg == RESP);
    err_o       = rsp_valid_o && err_c;
    rdata_o     = (rsp_valid_o && rd_reg && !err_c) ? load_data : 32'd0;
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: a byte-addressed reference memory
// with a request/response schedule is compared against the DUT on every
// cycle, alongside a few hand-computed directed expectations.
module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [1:0]  size_i = 2'd0;
  logic        sign_i = 1'b0;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .rd_en_i(rd_en_i),
    .wr_en_i(wr_en_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .size_i(size_i),
    .sign_i(sign_i),
    .rsp_valid_o(rsp_valid_o),
    .rdata_o(rdata_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference memory, byte addressed, little-endian.
  logic [7:0] mem_b [4*DEPTH];

  function automatic void model_access(input txn_t t, output logic err, output logic [31:0] rdata);
    int nb;
    int a;
    logic [31:0] v;
    nb = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
    err = (t.size == 2'd3)
       || ((t.size == 2'd1) && t.addr[0])
       || ((t.size == 2'd2) && (t.addr[1:0] != 2'b00))
       || ({2'b00, t.addr[31:2]} >= 32'(DEPTH))
       || (t.rd == t.wr);
    rdata = 32'd0;
    if (!err) begin
      a = int'(t.addr);
      if (t.wr) begin
        for (int i = 0; i < nb; i++) mem_b[a+i] = t.wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a+i]) << (8*i));
        if (nb < 4 && !t.sign && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rdata = v;
      end
    end
  endfunction

  // Schedule model: a request seen while the block should be free is
  // accepted at the next edge and answered LATENCY cycles later.
  bit          pending = 1'b0;
  int          due = 0;
  txn_t        p_txn;
  logic        exp_ready, exp_valid, exp_err;
  logic [31:0] exp_rdata;

  always @(negedge clk) begin
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = 32'd0;
    if (rst_i) begin
      pending   = 1'b0;
      exp_ready = 1'b1;
    end else begin
      exp_ready = !pending;
      if (pending && cyc == due) begin
        exp_valid = 1'b1;
        model_access(p_txn, exp_err, exp_rdata);
        pending = 1'b0;
        rsp_count++;
        $display("txn %0d rd=%0b wr=%0b addr=%08h size=%0d sign=%0b wdata=%08h -> err=%0b rdata=%08h",
                 rsp_count, p_txn.rd, p_txn.wr, p_txn.addr, p_txn.size, p_txn.sign,
                 p_txn.wdata, exp_err, exp_rdata);
      end
    end
    chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
    chk("rdata", rdata_o, exp_rdata);
    chk("err", 32'(err_o), 32'(exp_err));
    if (!rst_i && exp_ready && req_valid_i) begin
      pending = 1'b1;
      due     = cyc + 1 + LAT;
      p_txn   = '{rd: rd_en_i, wr: wr_en_i, addr: addr_i, wdata: wdata_i,
                  size: size_i, sign: sign_i};
    end
  end

  task automatic scramble();
    rd_en_i = 1'($urandom);
    wr_en_i = 1'($urandom);
    addr_i  = $urandom;
    wdata_i = $urandom;
    size_i  = 2'($urandom);
    sign_i  = 1'($urandom);
  endtask

  task automatic drive(input txn_t t);
    rd_en_i = t.rd;
    wr_en_i = t.wr;
    addr_i  = t.addr;
    wdata_i = t.wdata;
    size_i  = t.size;
    sign_i  = t.sign;
  endtask

  // Issue one request (called just after a rising edge) and return the
  // response; junk is driven on the inputs while the request is in flight.
  task automatic issue(input txn_t t, output logic [31:0] rdata, output logic err);
    int n;
    drive(t);
    req_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready_o) chk("accept_wait", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    scramble();
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rsp_latency", 32'(n), 32'(LAT));
    rdata = rdata_o;
    err   = err_o;
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sign);
    txn_t t;
    t = '{rd: rd, wr: wr, addr: addr, wdata: wdata, size: size, sign: sign};
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd_v;
    logic        er_v;
    int          pulses;
    txn_t        t;
    int          r;
    logic [31:0] widx;

    // Reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Initialise every word the random phase can reach.
    for (int w = 0; w < 64; w++) issue(mk(0, 1, 32'(4*w), $urandom, 2'd2, 0), rd_v, er_v);
    for (int w = DEPTH-2; w < DEPTH; w++) issue(mk(0, 1, 32'(4*w), $urandom, 2'd2, 0), rd_v, er_v);

    // Directed, hand-computed expectations
    issue(mk(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0), rd_v, er_v);
    chk("store_word_rdata", rd_v, 32'd0);
    chk("store_word_err", 32'(er_v), 32'd0);
    issue(mk(1, 0, 32'h10, 32'h0, 2'd2, 0), rd_v, er_v);
    chk("load_word", rd_v, 32'hDEADBEEF);
    chk("load_word_err", 32'(er_v), 32'd0);
    issue(mk(1, 0, 32'h13, 32'h0, 2'd0, 0), rd_v, er_v);
    chk("load_byte_sext", rd_v, 32'hFFFFFFDE);
    issue(mk(1, 0, 32'h13, 32'h0, 2'd0, 1), rd_v, er_v);
    chk("load_byte_zext", rd_v, 32'h000000DE);
    issue(mk(1, 0, 32'h12, 32'h0, 2'd1, 0), rd_v, er_v);
    chk("load_half_sext", rd_v, 32'hFFFFDEAD);
    issue(mk(0, 1, 32'h11, 32'hAAAAAA55, 2'd0, 0), rd_v, er_v);
    issue(mk(1, 0, 32'h10, 32'h0, 2'd2, 1), rd_v, er_v);
    chk("byte_merge", rd_v, 32'hDEAD55EF);
    issue(mk(0, 1, 32'h12, 32'h11223344, 2'd2, 0), rd_v, er_v);
    chk("misaligned_err", 32'(er_v), 32'd1);
    chk("misaligned_rdata", rd_v, 32'd0);
    issue(mk(1, 0, 32'h10, 32'h0, 2'd2, 0), rd_v, er_v);
    chk("after_err_unchanged", rd_v, 32'hDEAD55EF);
    issue(mk(1, 0, 32'(4*DEPTH), 32'h0, 2'd2, 0), rd_v, er_v);
    chk("oor_err", 32'(er_v), 32'd1);
    issue(mk(1, 1, 32'h10, 32'h0, 2'd2, 0), rd_v, er_v);
    chk("rd_and_wr_err", 32'(er_v), 32'd1);

    // Continuous request: one response per accept, LATENCY+2 cycle cadence.
    drive(mk(1, 0, 32'h10, 32'h0, 2'd2, 0));
    req_valid_i = 1'b1;
    pulses = 0;
    repeat (3*(LAT+2)) begin
      @(negedge clk);
      if (rsp_valid_o) pulses++;
      @(posedge clk);
    end
    #1;
    req_valid_i = 1'b0;
    repeat (LAT+4) begin
      @(negedge clk);
      if (rsp_valid_o) pulses++;
    end
    chk("held_valid_pulses", 32'(pulses), 32'd3);
    @(posedge clk);
    #1;

    // Reset in the middle of a pending store
    issue(mk(0, 1, 32'h20, 32'hCAFEF00D, 2'd2, 0), rd_v, er_v);
    drive(mk(0, 1, 32'h20, 32'h12345678, 2'd2, 0));
    req_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rst_ready_now", 32'(req_ready_o), 32'd1);
    chk("rst_valid_now", 32'(rsp_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    pulses = 0;
    repeat (LAT+3) begin
      @(negedge clk);
      if (rsp_valid_o) pulses++;
    end
    chk("rst_no_response", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    issue(mk(1, 0, 32'h20, 32'h0, 2'd2, 0), rd_v, er_v);
    chk("rst_store_cancelled", rd_v, 32'hCAFEF00D);

    // Randomized traffic against the reference model
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 99));
      t.size = (r < 8) ? 2'd3 : 2'($urandom_range(0, 2));
      r = int'($urandom_range(0, 99));
      if (r < 5)       begin t.rd = 1; t.wr = 1; end
      else if (r < 10) begin t.rd = 0; t.wr = 0; end
      else             begin t.rd = 1'($urandom); t.wr = !t.rd; end
      r = int'($urandom_range(0, 99));
      widx = (r < 85) ? 32'($urandom_range(0, 63)) : 32'(DEPTH - 2 + int'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 99));
      if (r < 80) begin
        case (t.size)
          2'd0:    t.addr = {widx[29:0], 2'($urandom)};
          2'd1:    t.addr = {widx[29:0], 1'($urandom), 1'b0};
          default: t.addr = {widx[29:0], 2'b00};
        endcase
      end else begin
        t.addr = {widx[29:0], 2'($urandom)};
      end
      t.wdata = $urandom;
      t.sign  = 1'($urandom);
      issue(t, rd_v, er_v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
